// File: rtl/ahb_slave_mem_arb.sv
// -----------------------------------------------------------------------------
// ahb_slave_mem_arb
// Shares one single-port RAM between two AHB slave-stub memory requesters.
// Each port owns one write slot (addr/data/bsel) and one read slot (addr).
// A round-robin arbiter issues at most one RAM op per cycle straight from the
// slot flops. Read data returns to the owning port one cycle after issue.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   WRn, ADDR_WRn, DINn, BSELn write request / address / data / byte enables
//   RDn, ADDR_RDn              read request / address
//   STALLn                     port busy, requests ignored while high
//   DOUTn, RVALIDn             read data (0 unless RVALIDn) and its valid
//   MEM_WR, MEM_RD             RAM write / read strobes
//   MEM_ADDR, MEM_DIN          RAM address and write data
//   MEM_BSEL                   RAM byte enables (0 on read or idle)
//   MEM_DOUT                   RAM read data, valid one cycle after MEM_RD
// -----------------------------------------------------------------------------
module ahb_slave_mem_arb #(
   parameter int ADDR_BITS = 24,
   parameter int DATA_BITS = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     WR0,
   input  logic [ADDR_BITS-1:0]     ADDR_WR0,
   input  logic [DATA_BITS-1:0]     DIN0,
   input  logic [DATA_BITS/8-1:0]   BSEL0,
   input  logic                     RD0,
   input  logic [ADDR_BITS-1:0]     ADDR_RD0,
   output logic                     STALL0,
   output logic [DATA_BITS-1:0]     DOUT0,
   output logic                     RVALID0,
   input  logic                     WR1,
   input  logic [ADDR_BITS-1:0]     ADDR_WR1,
   input  logic [DATA_BITS-1:0]     DIN1,
   input  logic [DATA_BITS/8-1:0]   BSEL1,
   input  logic                     RD1,
   input  logic [ADDR_BITS-1:0]     ADDR_RD1,
   output logic                     STALL1,
   output logic [DATA_BITS-1:0]     DOUT1,
   output logic                     RVALID1,
   output logic                     MEM_WR,
   output logic                     MEM_RD,
   output logic [ADDR_BITS-1:0]     MEM_ADDR,
   output logic [DATA_BITS-1:0]     MEM_DIN,
   output logic [DATA_BITS/8-1:0]   MEM_BSEL,
   input  logic [DATA_BITS-1:0]     MEM_DOUT
);

   localparam int BSEL_BITS = DATA_BITS / 8;

   // Slot state per port; bit 0 = write slot valid, bit 1 = read slot valid.
   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'b00,
      SLOT_W     = 2'b01,
      SLOT_R     = 2'b10,
      SLOT_WR    = 2'b11
   } slot_t;

   slot_t                slot_q  [2];
   slot_t                slot_d  [2];
   logic [ADDR_BITS-1:0] waddr_q [2];
   logic [ADDR_BITS-1:0] waddr_d [2];
   logic [DATA_BITS-1:0] wdata_q [2];
   logic [DATA_BITS-1:0] wdata_d [2];
   logic [BSEL_BITS-1:0] wbsel_q [2];
   logic [BSEL_BITS-1:0] wbsel_d [2];
   logic [ADDR_BITS-1:0] raddr_q [2];
   logic [ADDR_BITS-1:0] raddr_d [2];
   logic                 rr_q;
   logic                 rr_d;
   logic [1:0]           ret_q;     // one-hot owner of the read in flight
   logic [1:0]           ret_d;
   logic [1:0]           stall_q;
   logic [1:0]           stall_d;

   logic [1:0]           wr_in;
   logic [1:0]           rd_in;
   logic [ADDR_BITS-1:0] addr_wr_in [2];
   logic [ADDR_BITS-1:0] addr_rd_in [2];
   logic [DATA_BITS-1:0] din_in     [2];
   logic [BSEL_BITS-1:0] bsel_in    [2];

   logic [1:0]           pend;
   logic                 gnt;
   logic                 issue_valid;

   assign wr_in         = {WR1, WR0};
   assign rd_in         = {RD1, RD0};
   assign addr_wr_in[0] = ADDR_WR0;
   assign addr_wr_in[1] = ADDR_WR1;
   assign addr_rd_in[0] = ADDR_RD0;
   assign addr_rd_in[1] = ADDR_RD1;
   assign din_in[0]     = DIN0;
   assign din_in[1]     = DIN1;
   assign bsel_in[0]    = BSEL0;
   assign bsel_in[1]    = BSEL1;

   // Arbitration: a lone requester wins; on a tie the port other than rr_q wins.
   always_comb begin
      pend[0]     = (slot_q[0] != SLOT_EMPTY);
      pend[1]     = (slot_q[1] != SLOT_EMPTY);
      issue_valid = pend[0] | pend[1];
      if (pend[0] && pend[1]) begin
         gnt = ~rr_q;
      end else if (pend[1]) begin
         gnt = 1'b1;
      end else begin
         gnt = 1'b0;
      end
   end

   // RAM command driven straight from the granted port's slots; write goes before read.
   always_comb begin
      MEM_WR   = 1'b0;
      MEM_RD   = 1'b0;
      MEM_ADDR = {ADDR_BITS{1'b0}};
      MEM_DIN  = {DATA_BITS{1'b0}};
      MEM_BSEL = {BSEL_BITS{1'b0}};
      if (issue_valid) begin
         case (slot_q[gnt])
            SLOT_W, SLOT_WR: begin
               MEM_WR   = 1'b1;
               MEM_ADDR = waddr_q[gnt];
               MEM_DIN  = wdata_q[gnt];
               MEM_BSEL = wbsel_q[gnt];
            end
            SLOT_R: begin
               MEM_RD   = 1'b1;
               MEM_ADDR = raddr_q[gnt];
            end
            default: begin
               MEM_WR   = 1'b0;
            end
         endcase
      end else begin
         MEM_RD = 1'b0;
      end
   end

   // Next state: clear the issued slot, mark the read owner, accept new requests.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         slot_d[n]  = slot_q[n];
         waddr_d[n] = waddr_q[n];
         wdata_d[n] = wdata_q[n];
         wbsel_d[n] = wbsel_q[n];
         raddr_d[n] = raddr_q[n];
      end
      rr_d    = rr_q;
      ret_d   = 2'b00;
      stall_d = 2'b00;

      if (issue_valid) begin
         rr_d = gnt;
         case (slot_q[gnt])
            SLOT_WR: slot_d[gnt] = SLOT_R;
            SLOT_W:  slot_d[gnt] = SLOT_EMPTY;
            SLOT_R: begin
               slot_d[gnt] = SLOT_EMPTY;
               ret_d[gnt]  = 1'b1;
            end
            default: slot_d[gnt] = slot_q[gnt];
         endcase
      end else begin
         rr_d = rr_q;
      end

      // A non-stalled port has empty slots, so accepting never collides with a clear.
      for (int n = 0; n < 2; n++) begin
         if (!stall_q[n]) begin
            slot_d[n] = slot_t'({rd_in[n], wr_in[n]});
            if (wr_in[n]) begin
               waddr_d[n] = addr_wr_in[n];
               wdata_d[n] = din_in[n];
               wbsel_d[n] = bsel_in[n];
            end else begin
               waddr_d[n] = waddr_q[n];
            end
            if (rd_in[n]) begin
               raddr_d[n] = addr_rd_in[n];
            end else begin
               raddr_d[n] = raddr_q[n];
            end
         end else begin
            raddr_d[n] = raddr_q[n];
         end
         // Port stays busy until its slots drain and its read data has been returned.
         stall_d[n] = (slot_d[n] != SLOT_EMPTY) | ret_d[n];
      end
   end

   // State registers with synchronous reset; pointer resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < 2; n++) begin
            slot_q[n]  <= SLOT_EMPTY;
            waddr_q[n] <= {ADDR_BITS{1'b0}};
            wdata_q[n] <= {DATA_BITS{1'b0}};
            wbsel_q[n] <= {BSEL_BITS{1'b0}};
            raddr_q[n] <= {ADDR_BITS{1'b0}};
         end
         rr_q    <= 1'b1;
         ret_q   <= 2'b00;
         stall_q <= 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            slot_q[n]  <= slot_d[n];
            waddr_q[n] <= waddr_d[n];
            wdata_q[n] <= wdata_d[n];
            wbsel_q[n] <= wbsel_d[n];
            raddr_q[n] <= raddr_d[n];
         end
         rr_q    <= rr_d;
         ret_q   <= ret_d;
         stall_q <= stall_d;
      end
   end

   assign STALL0  = stall_q[0];
   assign STALL1  = stall_q[1];
   assign RVALID0 = ret_q[0];
   assign RVALID1 = ret_q[1];
   // MEM_DOUT is only forwarded to the port whose read is returning this cycle.
   assign DOUT0   = ret_q[0] ? MEM_DOUT : {DATA_BITS{1'b0}};
   assign DOUT1   = ret_q[1] ? MEM_DOUT : {DATA_BITS{1'b0}};

endmodule

// File: tb/tb_ahb_slave_mem_arb.sv
module tb_ahb_slave_mem_arb;

   localparam int AB = 24;
   localparam int DB = 32;
   localparam int BB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          WR0, WR1, RD0, RD1;
   logic [AB-1:0] ADDR_WR0, ADDR_WR1, ADDR_RD0, ADDR_RD1;
   logic [DB-1:0] DIN0, DIN1;
   logic [BB-1:0] BSEL0, BSEL1;
   logic          STALL0, STALL1, RVALID0, RVALID1;
   logic [DB-1:0] DOUT0, DOUT1;
   logic          MEM_WR, MEM_RD;
   logic [AB-1:0] MEM_ADDR;
   logic [DB-1:0] MEM_DIN;
   logic [BB-1:0] MEM_BSEL;
   logic [DB-1:0] MEM_DOUT = 32'h0;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ahb_slave_mem_arb #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk(clk), .reset(reset),
      .WR0(WR0), .ADDR_WR0(ADDR_WR0), .DIN0(DIN0), .BSEL0(BSEL0),
      .RD0(RD0), .ADDR_RD0(ADDR_RD0), .STALL0(STALL0), .DOUT0(DOUT0), .RVALID0(RVALID0),
      .WR1(WR1), .ADDR_WR1(ADDR_WR1), .DIN1(DIN1), .BSEL1(BSEL1),
      .RD1(RD1), .ADDR_RD1(ADDR_RD1), .STALL1(STALL1), .DOUT1(DOUT1), .RVALID1(RVALID1),
      .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
      .MEM_BSEL(MEM_BSEL), .MEM_DOUT(MEM_DOUT)
   );

   // ---------------- RAM stub (environment) ----------------
   logic [DB-1:0] ram [int unsigned];
   logic          pre_en = 1'b0;
   logic [AB-1:0] pre_addr = 24'h0;
   logic [DB-1:0] pre_data = 32'h0;

   function automatic logic [DB-1:0] def_val(input logic [AB-1:0] a);
      return {8'h5A, a};
   endfunction

   function automatic logic [DB-1:0] merge(input logic [DB-1:0] old, input logic [DB-1:0] din,
                                           input logic [BB-1:0] bsel);
      logic [DB-1:0] r;
      r = old;
      for (int b = 0; b < BB; b++) if (bsel[b]) r[8*b +: 8] = din[8*b +: 8];
      return r;
   endfunction

   function automatic logic [DB-1:0] ram_rd(input logic [AB-1:0] a);
      if (ram.exists({8'h00, a})) return ram[{8'h00, a}];
      return def_val(a);
   endfunction

   // RAM: writes land at the edge, read data appears the cycle after MEM_RD, junk otherwise
   always @(posedge clk) begin
      if (pre_en) ram[{8'h00, pre_addr}] = pre_data;
      if (MEM_WR) ram[{8'h00, MEM_ADDR}] = merge(ram_rd(MEM_ADDR), MEM_DIN, MEM_BSEL);
      if (MEM_RD) MEM_DOUT <= ram_rd(MEM_ADDR);
      else        MEM_DOUT <= $urandom();
   end

   // ---------------- reference model state ----------------
   typedef struct {
      bit            is_wr;
      logic [AB-1:0] addr;
      logic [DB-1:0] data;
      logic [BB-1:0] bsel;
   } op_t;

   op_t           pq [2][$];
   logic [DB-1:0] refm [int unsigned];

   function automatic logic [DB-1:0] ref_rd(input logic [AB-1:0] a);
      if (refm.exists({8'h00, a})) return refm[{8'h00, a}];
      return def_val(a);
   endfunction

   // ---------------- helpers (stimulus only) ----------------
   task automatic idle_inputs();
      WR0 = 1'b0; WR1 = 1'b0; RD0 = 1'b0; RD1 = 1'b0;
      ADDR_WR0 = 24'h0; ADDR_WR1 = 24'h0; ADDR_RD0 = 24'h0; ADDR_RD1 = 24'h0;
      DIN0 = 32'h0; DIN1 = 32'h0; BSEL0 = 4'h0; BSEL1 = 4'h0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [127:0] g, e;
      do_reset();
      g = {STALL0, STALL1, RVALID0, RVALID1, MEM_WR, MEM_RD, MEM_ADDR, MEM_DIN, MEM_BSEL};
      e = 128'h0;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", g, e); end
      g = {DOUT0, DOUT1};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL reset_dout: got %h want %h", g, e); end
   endtask

   task automatic test_single_read();
      logic [127:0] g, e;
      preload(24'h10, 32'hA5A5A5A5);
      do_reset();
      RD0 = 1'b1; ADDR_RD0 = 24'h10;
      tick(); idle_inputs();                       // c1
      g = {STALL0, MEM_WR, MEM_RD, MEM_ADDR, MEM_BSEL};
      e = {1'b1, 1'b0, 1'b1, 24'h10, 4'h0};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL single_read_c1: got %h want %h", g, e); end
      tick();                                      // c2
      g = {STALL0, RVALID0, DOUT0, RVALID1, DOUT1, MEM_RD};
      e = {1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL single_read_c2: got %h want %h", g, e); end
      tick();                                      // c3
      g = {STALL0, RVALID0, DOUT0};
      e = 128'h0;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL single_read_c3: got %h want %h", g, e); end
   endtask

   task automatic test_write_read();
      logic [127:0] g, e;
      do_reset();
      WR0 = 1'b1; ADDR_WR0 = 24'h20; DIN0 = 32'h11223344; BSEL0 = 4'hF;
      RD0 = 1'b1; ADDR_RD0 = 24'h20;
      tick(); idle_inputs();                       // c1
      g = {STALL0, MEM_WR, MEM_RD, MEM_ADDR, MEM_DIN, MEM_BSEL};
      e = {1'b1, 1'b1, 1'b0, 24'h20, 32'h11223344, 4'hF};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL wr_rd_c1: got %h want %h", g, e); end
      tick();                                      // c2
      g = {STALL0, MEM_WR, MEM_RD, MEM_ADDR, MEM_DIN, MEM_BSEL, RVALID0};
      e = {1'b1, 1'b0, 1'b1, 24'h20, 32'h0, 4'h0, 1'b0};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL wr_rd_c2: got %h want %h", g, e); end
      tick();                                      // c3
      g = {RVALID0, DOUT0};
      e = {1'b1, 32'h11223344};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL wr_rd_c3: got %h want %h", g, e); end
      tick();                                      // c4
      n_cmp++;
      if (STALL0 !== 1'b0) begin n_fail++; $display("FAIL wr_rd_c4_stall: got %b want 0", STALL0); end
   endtask

   task automatic test_contention();
      logic [127:0] g, e;
      do_reset();
      RD0 = 1'b1; ADDR_RD0 = 24'h30;
      RD1 = 1'b1; ADDR_RD1 = 24'h40;
      tick(); idle_inputs();                       // c1
      g = {MEM_RD, MEM_ADDR, STALL0, STALL1};
      e = {1'b1, 24'h30, 1'b1, 1'b1};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL contention_c1: got %h want %h", g, e); end
      tick();                                      // c2
      g = {MEM_RD, MEM_ADDR, RVALID0, DOUT0, RVALID1, DOUT1, STALL1};
      e = {1'b1, 24'h40, 1'b1, def_val(24'h30), 1'b0, 32'h0, 1'b1};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL contention_c2: got %h want %h", g, e); end
      tick();                                      // c3
      g = {MEM_RD, RVALID0, DOUT0, RVALID1, DOUT1, STALL1};
      e = {1'b0, 1'b0, 32'h0, 1'b1, def_val(24'h40), 1'b1};
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL contention_c3: got %h want %h", g, e); end
      tick();                                      // c4
      g = {STALL0, STALL1};
      e = 128'h0;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL contention_c4: got %h want %h", g, e); end
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int prev   = -1;
      int gp, ep;
      do_reset();
      for (int cyc = 0; cyc < 23; cyc++) begin
         WR0 = (cyc < 20); ADDR_WR0 = 24'h100 + 24'(cyc); DIN0 = $urandom(); BSEL0 = 4'hF;
         WR1 = (cyc < 20); ADDR_WR1 = 24'h200 + 24'(cyc); DIN1 = $urandom(); BSEL1 = 4'hF;
         tick();
         if (MEM_WR) begin
            gp = (MEM_ADDR[11:8] == 4'h1) ? 0 : 1;
            ep = (prev < 0) ? 0 : 1 - prev;
            n_cmp++;
            if (gp != ep) begin n_fail++; $display("FAIL rr_order: got port %0d want port %0d (grant %0d)", gp, ep, grants); end
            prev = gp;
            grants++;
         end
      end
      idle_inputs();
      n_cmp++;
      if (grants != 20) begin n_fail++; $display("FAIL rr_grant_count: got %0d want 20", grants); end
   endtask

   task automatic test_ignore_stalled();
      int n50 = 0, n60 = 0, npulse = 0, bad_dout = 0;
      do_reset();
      RD1 = 1'b1; ADDR_RD1 = 24'h50;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin
            n_cmp++;
            if (STALL1 !== 1'b1) begin n_fail++; $display("FAIL ignore_stall1: got %b want 1", STALL1); end
            ADDR_RD1 = 24'h60;                       // re-request while stalled
         end else begin
            RD1 = 1'b0;
         end
         if (MEM_RD && MEM_ADDR == 24'h50) n50++;
         if (MEM_RD && MEM_ADDR == 24'h60) n60++;
         if (RVALID1) begin
            npulse++;
            if (DOUT1 !== def_val(24'h50)) bad_dout++;
         end
      end
      n_cmp++;
      if (n50 != 1 || n60 != 0) begin n_fail++; $display("FAIL ignore_addr: got n50=%0d n60=%0d want 1 0", n50, n60); end
      n_cmp++;
      if (npulse != 1 || bad_dout != 0) begin n_fail++; $display("FAIL ignore_rvalid: got pulses=%0d bad=%0d want 1 0", npulse, bad_dout); end
   endtask

   task automatic test_reset_mid_read();
      logic [127:0] g, e;
      int late = 0;
      do_reset();
      RD0 = 1'b1; ADDR_RD0 = 24'h70;
      tick(); idle_inputs();                       // c1
      n_cmp++;
      if (MEM_RD !== 1'b1) begin n_fail++; $display("FAIL midrst_issue: got %b want 1", MEM_RD); end
      reset = 1'b1;
      tick();                                      // c2, after reset edge
      reset = 1'b0;
      g = {RVALID0, RVALID1, STALL0, STALL1, MEM_WR, MEM_RD, MEM_ADDR, MEM_DIN, MEM_BSEL};
      e = 128'h0;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL midrst_after: got %h want %h", g, e); end
      n_cmp++;
      if ({DOUT0, DOUT1} !== 64'h0) begin n_fail++; $display("FAIL midrst_dout: got %h want 0", {DOUT0, DOUT1}); end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (RVALID0 || RVALID1) late++;
      end
      n_cmp++;
      if (late != 0) begin n_fail++; $display("FAIL midrst_late_rvalid: got %0d want 0", late); end
   endtask

   task automatic test_random();
      logic [127:0] g, e;
      int            ret, nret, last, gp;
      logic [DB-1:0] ret_data, nret_data;
      bit            busy [2];
      bit            wr [2], rd [2], do_rst;
      logic [AB-1:0] wa [2], ra [2];
      logic [DB-1:0] wd [2];
      logic [BB-1:0] wb [2];
      op_t           op;
      do_reset();
      pq[0].delete(); pq[1].delete();
      ret = -1; ret_data = 32'h0; last = 1;
      for (int cyc = 0; cyc < 500; cyc++) begin
         // expected view of this cycle from the model
         for (int n = 0; n < 2; n++) busy[n] = (pq[n].size() != 0) || (ret == n);
         if (pq[0].size() != 0 && pq[1].size() != 0) gp = 1 - last;
         else if (pq[0].size() != 0)                 gp = 0;
         else if (pq[1].size() != 0)                 gp = 1;
         else                                        gp = -1;
         g = {STALL0, STALL1, MEM_WR, MEM_RD, MEM_ADDR, MEM_DIN, MEM_BSEL};
         if (gp >= 0) begin
            op = pq[gp][0];
            e = {busy[0], busy[1], op.is_wr, !op.is_wr, op.addr,
                 op.is_wr ? op.data : 32'h0, op.is_wr ? op.bsel : 4'h0};
         end else begin
            e = {busy[0], busy[1], 1'b0, 1'b0, 24'h0, 32'h0, 4'h0};
         end
         n_cmp++;
         if (g !== e) begin n_fail++; $display("FAIL rand_mem cyc %0d: got %h want %h", cyc, g, e); end
         g = {RVALID0, DOUT0, RVALID1, DOUT1};
         e = {ret == 0, (ret == 0) ? ret_data : 32'h0, ret == 1, (ret == 1) ? ret_data : 32'h0};
         n_cmp++;
         if (g !== e) begin n_fail++; $display("FAIL rand_rdata cyc %0d: got %h want %h", cyc, g, e); end

         // new stimulus
         do_rst = ($urandom_range(0, 79) == 0);
         for (int n = 0; n < 2; n++) begin
            wr[n] = $urandom_range(0, 1); rd[n] = $urandom_range(0, 1);
            wa[n] = 24'h300 + 24'($urandom_range(0, 7));
            ra[n] = 24'h300 + 24'($urandom_range(0, 7));
            wd[n] = $urandom(); wb[n] = 4'($urandom_range(0, 15));
         end
         WR0 = wr[0]; ADDR_WR0 = wa[0]; DIN0 = wd[0]; BSEL0 = wb[0]; RD0 = rd[0]; ADDR_RD0 = ra[0];
         WR1 = wr[1]; ADDR_WR1 = wa[1]; DIN1 = wd[1]; BSEL1 = wb[1]; RD1 = rd[1]; ADDR_RD1 = ra[1];
         reset = do_rst;

         // model advance: the issued op always reaches the RAM, even in a reset cycle
         nret = -1; nret_data = 32'h0;
         if (gp >= 0) begin
            op = pq[gp].pop_front();
            last = gp;
            if (op.is_wr) refm[{8'h00, op.addr}] = merge(ref_rd(op.addr), op.data, op.bsel);
            else begin nret = gp; nret_data = ref_rd(op.addr); end
         end
         if (do_rst) begin
            pq[0].delete(); pq[1].delete();
            ret = -1; ret_data = 32'h0; last = 1;
         end else begin
            ret = nret; ret_data = nret_data;
            for (int n = 0; n < 2; n++) begin
               if (!busy[n]) begin
                  if (wr[n]) pq[n].push_back('{1'b1, wa[n], wd[n], wb[n]});
                  if (rd[n]) pq[n].push_back('{1'b0, ra[n], 32'h0, 4'h0});
               end
            end
         end
         tick();
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      tick();
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_round_robin();
      test_ignore_stalled();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
